// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg
//   Shared definitions for the Karatsuba multiplier arbiter slice.
//   - OPW  : operand width delivered to the multiplier (8 bits)
//   - RESW : product width returned by the multiplier (16 bits)
//   - arb_state_t : 2-bit arbiter FSM encoding (IDLE, ISSUE, WAIT, RESP)
package karatsuba_pkg;

  localparam int OPW  = 8;
  localparam int RESW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/karatsuba_rr_pick.sv
// karatsuba_rr_pick
//   Combinational round-robin search. Starting at index ptr and moving
//   upward (wrapping modulo NREQ), returns the first requester whose req
//   bit is set.
// Ports:
//   req         in  NREQ  request vector
//   ptr         in  IDW   search start index (always < NREQ)
//   grant_valid out 1     at least one request is set
//   grant_idx   out IDW   index of the selected requester
import karatsuba_pkg::*;

module karatsuba_rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_idx
);

  // rot_req[k] is the request of requester (ptr + k) mod NREQ, so the
  // lowest set bit of rot_req is the winner's distance from ptr.
  logic [NREQ-1:0] rot_req;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      // ptr < NREQ and gi < NREQ, so one conditional subtract wraps it.
      assign sum = {1'b0, ptr} + (IDW+1)'(gi);
      assign idx = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                           : sum[IDW-1:0];
      assign rot_req[gi] = req[idx];
    end
  endgenerate

  logic [IDW-1:0] offset;
  logic [IDW:0]   abs_sum;

  always_comb begin
    grant_valid = 1'b0;
    offset      = '0;
    // Descending scan so the lowest set distance wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        grant_valid = 1'b1;
        offset      = IDW'(k);
      end
    end
  end

  assign abs_sum   = {1'b0, ptr} + {1'b0, offset};
  assign grant_idx = (abs_sum >= (IDW+1)'(NREQ)) ? IDW'(abs_sum - (IDW+1)'(NREQ))
                                                 : abs_sum[IDW-1:0];

endmodule

// File: rtl/karatsuba_arbiter.sv
// karatsuba_arbiter
//   Round-robin arbiter sharing one 8x8 Karatsuba multiplier among NREQ
//   requesters. Captures the winner's operands, pulses MUL_START, waits for
//   MUL_DONE and returns the product tagged with the requester index.
//
//   Optional feature macro: KARATSUBA_ARB_TIMEOUT_EN
//     defined   : WAIT gives up after TIMEOUT cycles, returning RES=0, ERR=1
//     undefined : WAIT waits indefinitely, ERR tied to 0
//
// Parameters:
//   NREQ     number of requesters, 2..8
//   TIMEOUT  WAIT-state cycle limit (timeout build only), 1..255
// Ports:
//   CLK        in   1         clock, rising edge
//   RST        in   1         synchronous active-high reset
//   REQ        in   NREQ      level requests, sampled only in IDLE
//   LOADA      in   NREQ*8    packed operand A, slice i = [8i+7:8i]
//   LOADB      in   NREQ*8    packed operand B, same slicing
//   ACK        out  NREQ      one-hot pulse: operands captured
//   RES        out  16        product of the served request
//   RES_VALID  out  1         pulse: RES, RES_ID, ERR valid
//   RES_ID     out  IDW       index of the served requester
//   ERR        out  1         timeout flag, qualified by RES_VALID
//   BUSY       out  1         high whenever the FSM is not in IDLE
//   MUL_START  out  1         start pulse to the multiplier
//   MUL_A/B    out  8         operands to the multiplier
//   MUL_RES    in   16        multiplier product
//   MUL_DONE   in   1         multiplier completion (honoured only in WAIT)
import karatsuba_pkg::*;

module karatsuba_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ,
  input  logic [NREQ*OPW-1:0] LOADA,
  input  logic [NREQ*OPW-1:0] LOADB,
  output logic [NREQ-1:0]     ACK,
  output logic [RESW-1:0]     RES,
  output logic                RES_VALID,
  output logic [IDW-1:0]      RES_ID,
  output logic                ERR,
  output logic                BUSY,
  output logic                MUL_START,
  output logic [OPW-1:0]      MUL_A,
  output logic [OPW-1:0]      MUL_B,
  input  logic [RESW-1:0]     MUL_RES,
  input  logic                MUL_DONE
);

  // ---------------------------------------------------------------------
  // Operand unpacking and one-hot grant decode
  // ---------------------------------------------------------------------
  logic [OPW-1:0]  loada_arr [NREQ];
  logic [OPW-1:0]  loadb_arr [NREQ];
  logic [NREQ-1:0] ack_next;

  logic            grant_valid;
  logic [IDW-1:0]  grant_idx;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign loada_arr[gi] = LOADA[gi*OPW +: OPW];
      assign loadb_arr[gi] = LOADB[gi*OPW +: OPW];
      assign ack_next[gi]  = (grant_idx == IDW'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  arb_state_t      state_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [IDW-1:0]  id_reg;
  logic [OPW-1:0]  opa_reg;
  logic [OPW-1:0]  opb_reg;
  logic [RESW-1:0] res_reg;
  logic [NREQ-1:0] ack_reg;
  logic            start_reg;
  logic            valid_reg;
  logic [IDW-1:0]  res_id_reg;
  logic            busy_reg;

  karatsuba_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req         (REQ),
    .ptr         (ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Pointer advances to the requester after the one just served.
  logic [IDW-1:0] ptr_next;
  assign ptr_next = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + IDW'(1);

`ifdef KARATSUBA_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;
  logic       err_reg;
  logic       timeout_hit;

  // Fires on the TIMEOUT-th WAIT cycle: the counter holds the number of
  // WAIT cycles already completed.
  assign timeout_hit = (({1'b0, wait_cnt_reg} + 9'd1) == 9'(TIMEOUT));
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      id_reg     <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      res_reg    <= '0;
      ack_reg    <= '0;
      start_reg  <= 1'b0;
      valid_reg  <= 1'b0;
      res_id_reg <= '0;
      busy_reg   <= 1'b0;
`ifdef KARATSUBA_ARB_TIMEOUT_EN
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each state raises its own for one cycle.
      ack_reg   <= '0;
      start_reg <= 1'b0;
      valid_reg <= 1'b0;
`ifdef KARATSUBA_ARB_TIMEOUT_EN
      err_reg   <= 1'b0;
`endif

      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            opa_reg   <= loada_arr[grant_idx];
            opb_reg   <= loadb_arr[grant_idx];
            id_reg    <= grant_idx;
            // ACK/MUL_START are registered so they appear during ISSUE.
            ack_reg   <= ack_next;
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= ISSUE;
          end
        end

        ISSUE: begin
`ifdef KARATSUBA_ARB_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
          state_reg <= WAIT;
        end

        WAIT: begin
          if (MUL_DONE) begin
            res_reg    <= MUL_RES;
            valid_reg  <= 1'b1;
            res_id_reg <= id_reg;
            state_reg  <= RESP;
          end
`ifdef KARATSUBA_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            res_reg    <= '0;
            err_reg    <= 1'b1;
            valid_reg  <= 1'b1;
            res_id_reg <= id_reg;
            state_reg  <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
`endif
        end

        RESP: begin
          ptr_reg   <= ptr_next;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ACK       = ack_reg;
  assign RES       = res_reg;
  assign RES_VALID = valid_reg;
  assign RES_ID    = res_id_reg;
  assign BUSY      = busy_reg;
  assign MUL_START = start_reg;
  assign MUL_A     = opa_reg;
  assign MUL_B     = opb_reg;

`ifdef KARATSUBA_ARB_TIMEOUT_EN
  assign ERR = err_reg;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_karatsuba_arbiter.sv
// tb_karatsuba_arbiter
//   Directed bench for karatsuba_arbiter with NREQ=4 and a multiplier model
//   that raises DONE three cycles after START with RES=A*B.
//   Timeout scenario runs only when KARATSUBA_ARB_TIMEOUT_EN is defined.
module tb_karatsuba_arbiter;

  localparam int NREQ = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] loada;
  logic [31:0] loadb;
  logic [3:0]  ack;
  logic [15:0] res;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        err;
  logic        busy;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_res;
  logic        mul_done;

  int checks   = 0;
  int failures = 0;

  logic force_done = 1'b0;
  logic model_off  = 1'b0;

  karatsuba_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (64)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .LOADA     (loada),
    .LOADB     (loadb),
    .ACK       (ack),
    .RES       (res),
    .RES_VALID (res_valid),
    .RES_ID    (res_id),
    .ERR       (err),
    .BUSY      (busy),
    .MUL_START (mul_start),
    .MUL_A     (mul_a),
    .MUL_B     (mul_b),
    .MUL_RES   (mul_res),
    .MUL_DONE  (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: DONE during the third cycle after the START cycle.
  logic [7:0] m_a, m_b;
  logic [1:0] m_cnt;
  logic       m_active;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_cnt    <= 2'd0;
      m_a      <= 8'd0;
      m_b      <= 8'd0;
    end else if (mul_start) begin
      m_active <= 1'b1;
      m_cnt    <= 2'd1;
      m_a      <= mul_a;
      m_b      <= mul_b;
    end else if (m_active) begin
      if (m_cnt == 2'd3) m_active <= 1'b0;
      else               m_cnt    <= m_cnt + 2'd1;
    end
  end

  assign mul_done = force_done | (m_active && (m_cnt == 2'd3) && !model_off);
  assign mul_res  = {8'd0, m_a} * {8'd0, m_b};

  // ---------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------
  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
    loada[idx*8 +: 8] = a;
    loadb[idx*8 +: 8] = b;
  endtask

  task automatic wait_valid(input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      if (res_valid) begin
        seen = 1'b1;
        $display("txn id=%0d res=0x%04h err=%0b cycles=%0d", res_id, res, err, n);
      end
    end
  endtask

  task automatic wait_ack(input int limit, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      if (ack != 4'b0000) seen = 1'b1;
    end
  endtask

  task automatic run_txn(input int idx, input logic [7:0] a, input logic [7:0] b,
                         output bit ok);
    bit a_seen, v_seen;
    int n;
    set_op(idx, a, b);
    req = 4'b0001 << idx;
    wait_ack(10, a_seen);
    req = 4'b0000;
    wait_valid(30, n, v_seen);
    ok = a_seen && v_seen;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    loada = '0;
    loadb = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'b0000)    begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", mul_start); end
    checks++; if (res !== 16'd0)      begin failures++; $display("FAIL reset_res got=%0h exp=0", res); end
    checks++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin failures++; $display("FAIL reset_ops got=%0h/%0h exp=0/0", mul_a, mul_b); end
    checks++; if (res_id !== 2'd0 || err !== 1'b0) begin failures++; $display("FAIL reset_id_err got=%0d/%b exp=0/0", res_id, err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n, extra;
    bit seen;
    loada = {8'd9, 8'd7, 8'd12, 8'd5};
    loadb = {8'd4, 8'd3, 8'd13, 8'd2};
    req = 4'b0010;
    @(negedge clk);
    checks++; if (ack !== 4'b0010)    begin failures++; $display("FAIL single_ack got=%b exp=0010", ack); end
    checks++; if (mul_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", mul_start); end
    checks++; if (mul_a !== 8'd12 || mul_b !== 8'd13) begin failures++; $display("FAIL single_ops got=%0d/%0d exp=12/13", mul_a, mul_b); end
    checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    req = 4'b0000;
    wait_valid(20, n, seen);
    checks++; if (!seen)              begin failures++; $display("FAIL single_valid got=none exp=pulse"); end
    checks++; if (n != 4)             begin failures++; $display("FAIL single_latency got=%0d exp=4", n); end
    checks++; if (res !== 16'd156)    begin failures++; $display("FAIL single_res got=%0d exp=156", res); end
    checks++; if (res_id !== 2'd1)    begin failures++; $display("FAIL single_id got=%0d exp=1", res_id); end
    checks++; if (err !== 1'b0)       begin failures++; $display("FAIL single_err got=%b exp=0", err); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_after got=valid%b/busy%b exp=0/0", res_valid, busy); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack !== 4'b0000 || res_valid !== 1'b0) extra++;
    end
    checks++; if (extra != 0)         begin failures++; $display("FAIL single_norepeat got=%0d exp=0", extra); end
  endtask

  task automatic test_fairness();
    int n;
    bit seen;
    logic [15:0] exp_res;
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 2), 8'(i + 10));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_valid(30, n, seen);
      exp_res = 16'((k % 4 + 2) * (k % 4 + 10));
      checks++; if (!seen) begin failures++; $display("FAIL fair_valid_%0d got=none exp=pulse", k); end
      checks++; if (res_id !== 2'(k % 4)) begin failures++; $display("FAIL fair_id_%0d got=%0d exp=%0d", k, res_id, k % 4); end
      checks++; if (res !== exp_res) begin failures++; $display("FAIL fair_res_%0d got=%0d exp=%0d", k, res, exp_res); end
      checks++; if (n != ((k == 0) ? 5 : 6)) begin failures++; $display("FAIL fair_period_%0d got=%0d exp=%0d", k, n, (k == 0) ? 5 : 6); end
      if (k == 5) req = 4'b0000;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_extremes();
    bit ok;
    run_txn(2, 8'd255, 8'd255, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ext_ff_handshake got=timeout exp=ack+valid"); end
    checks++; if (res !== 16'hFE01 || res_id !== 2'd2) begin failures++; $display("FAIL ext_ff got=%04h id%0d exp=fe01 id2", res, res_id); end
    run_txn(3, 8'd0, 8'd200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ext_zero_handshake got=timeout exp=ack+valid"); end
    checks++; if (res !== 16'h0000 || res_id !== 2'd3) begin failures++; $display("FAIL ext_zero got=%04h id%0d exp=0000 id3", res, res_id); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spurious_done();
    int vcnt, starts, acks;
    logic [15:0] r;
    force_done = 1'b1;
    req = 4'b0000;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid) vcnt++;
    end
    checks++; if (vcnt != 0)    begin failures++; $display("FAIL spur_idle_valid got=%0d exp=0", vcnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_idle_busy got=%b exp=0", busy); end
    set_op(0, 8'd3, 8'd5);
    req = 4'b0001;
    starts = 0; vcnt = 0; acks = 0; r = '0;
    repeat (12) begin
      @(negedge clk);
      if (mul_start) starts++;
      if (ack[0]) begin acks++; req = 4'b0000; end
      if (res_valid) begin
        vcnt++;
        r = res;
        $display("txn id=%0d res=0x%04h err=%0b spurious", res_id, res, err);
      end
    end
    force_done = 1'b0;
    checks++; if (starts != 1) begin failures++; $display("FAIL spur_start got=%0d exp=1", starts); end
    checks++; if (vcnt != 1)   begin failures++; $display("FAIL spur_valid got=%0d exp=1", vcnt); end
    checks++; if (r !== 16'd15) begin failures++; $display("FAIL spur_res got=%0d exp=15", r); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n, vcnt;
    set_op(1, 8'd6, 8'd7);
    req = 4'b0010;
    wait_ack(10, seen);
    req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_inwait got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", res_valid); end
    checks++; if (res !== 16'd0)      begin failures++; $display("FAIL mid_res got=%0d exp=0", res); end
    rst = 1'b0;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid) vcnt++;
    end
    checks++; if (vcnt != 0) begin failures++; $display("FAIL mid_discard got=%0d exp=0", vcnt); end
    set_op(0, 8'd4, 8'd6);
    set_op(3, 8'd7, 8'd8);
    req = 4'b1001;
    wait_ack(10, seen);
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL mid_first_ack got=%b exp=0001", ack); end
    req = 4'b1000;
    wait_valid(20, n, seen);
    checks++; if (!seen || res_id !== 2'd0 || res !== 16'd24) begin failures++; $display("FAIL mid_first_res got=id%0d/%0d exp=id0/24", res_id, res); end
    wait_ack(10, seen);
    checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL mid_second_ack got=%b exp=1000", ack); end
    req = 4'b0000;
    wait_valid(20, n, seen);
    checks++; if (!seen || res_id !== 2'd3 || res !== 16'd56) begin failures++; $display("FAIL mid_second_res got=id%0d/%0d exp=id3/56", res_id, res); end
    repeat (3) @(negedge clk);
  endtask

`ifdef KARATSUBA_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen, ok;
    int n;
    model_off = 1'b1;
    set_op(2, 8'd9, 8'd9);
    req = 4'b0100;
    wait_ack(10, seen);
    req = 4'b0000;
    wait_valid(100, n, seen);
    checks++; if (!seen)          begin failures++; $display("FAIL to_valid got=none exp=pulse"); end
    checks++; if (n != 65)        begin failures++; $display("FAIL to_latency got=%0d exp=65", n); end
    checks++; if (err !== 1'b1)   begin failures++; $display("FAIL to_err got=%b exp=1", err); end
    checks++; if (res !== 16'd0 || res_id !== 2'd2) begin failures++; $display("FAIL to_res got=%0d id%0d exp=0 id2", res, res_id); end
    model_off = 1'b0;
    repeat (4) @(negedge clk);
    run_txn(3, 8'd10, 8'd11, ok);
    checks++; if (!ok || res !== 16'd110 || err !== 1'b0 || res_id !== 2'd3) begin failures++; $display("FAIL to_next got=%0d err%b id%0d exp=110 err0 id3", res, err, res_id); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_extremes();
    test_spurious_done();
    test_reset_mid();
`ifdef KARATSUBA_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/karatsuba_arbiter.md
# karatsuba_arbiter

Round-robin arbiter that shares one 8x8 Karatsuba multiplier unit among NREQ requesters. It captures one requester's operands, drives the multiplier's START/DONE handshake, and returns the 16-bit product tagged with the requester index. It sits between the requesting blocks and a single `karatsuba` instance, which it drives through its LOADA/LOADB/START/RES/DONE ports.

## Interface

- NREQ, 4: number of requesters; 2..8.
- TIMEOUT, 64: WAIT-state cycle limit. Used only with KARATSUBA_ARB_TIMEOUT_EN.

Ports:

- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NREQ  level request, one bit per requester.
- LOADA  in  NREQ*8  packed operand A; slice i = LOADA[8i+7:8i].
- LOADB  in  NREQ*8  packed operand B; same slicing as LOADA.
- ACK  out  NREQ  one-hot, one-cycle pulse: the requester's operands were captured.
- RES  out  16  product of the served request.
- RES_VALID  out  1  one-cycle pulse: RES, RES_ID and ERR are valid.
- RES_ID  out  $clog2(NREQ)  index of the served requester.
- ERR  out  1  timeout flag, qualified by RES_VALID.
- BUSY  out  1  high in every state except IDLE.
- MUL_START  out  1  start pulse to the multiplier.
- MUL_A, MUL_B  out  8  operands to the multiplier.
- MUL_RES  in  16  multiplier product.
- MUL_DONE  in  1  multiplier completion.

## Operation

- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any REQ bit is high:
  - Pick the first set bit at or after the pointer PTR, searching upward and wrapping modulo NREQ.
  - Register that requester's LOADA/LOADB slices into OPA/OPB and its index into ID.
  - Go to ISSUE.
- IDLE, when REQ is zero: stay in IDLE.
- ISSUE:
  - Drive MUL_START=1 and ACK[ID]=1 for this one cycle.
  - Go to WAIT.
- WAIT:
  - On MUL_DONE=1, register MUL_RES into RES and go to RESP.
  - Otherwise stay in WAIT.
- RESP:
  - Drive RES_VALID=1 and RES_ID=ID for this one cycle.
  - Set PTR=(ID+1) mod NREQ.
  - Go to IDLE.
- MUL_A=OPA and MUL_B=OPB, held stable from ISSUE until the next capture.
- REQ is sampled only in IDLE.
  - A requester whose REQ is still high when the FSM next reaches IDLE gets a new transaction with its current operands.
  - A requester wanting a single operation drops REQ on ACK.
- MUL_DONE is ignored outside WAIT, including a stale DONE left over from before reset.
- The arbiter does not compute: RES is MUL_RES unmodified, zero-extended as delivered.
- Reset, synchronous and taking effect at any state:
  - State=IDLE, PTR=0, RES=0, OPA=OPB=0, ID=0.
  - All outputs are 0.
  - An in-flight result is discarded and produces no RES_VALID.

## Timing

- A request sampled at edge n gives ACK and MUL_START during cycle n+1.
- A MUL_DONE sampled at edge m (in WAIT) gives RES_VALID during cycle m+1, and the FSM is in IDLE at m+2.
- Minimum transaction is 4 cycles: IDLE, ISSUE, WAIT, RESP (WAIT lasts at least 1 cycle).
- Throughput is one product per 3+k cycles, where k is the number of WAIT cycles.
- A requester continuously denied in favour of others waits at most NREQ-1 transactions.

## Configuration

- Macro: KARATSUBA_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with MUL_DONE still 0, the FSM goes to RESP with RES=0 and ERR=1.
- When undefined:
  - There is no counter, and WAIT waits indefinitely.
  - ERR is tied to 0.

## Structure

- The shared package karatsuba_pkg holds:
  - the state encoding (2-bit enum: IDLE, ISSUE, WAIT, RESP);
  - OPW=8 and RESW=16.
- Sub-module karatsuba_rr_pick is combinational. It takes REQ and PTR and returns grant_valid and grant_idx. It contains the wrap-around priority search.

## Test plan

The bench uses NREQ=4 and a multiplier model that asserts DONE 3 cycles after START with RES=A*B.

- Single requester: REQ=0010, operands 12 and 13 -> ACK=0010 for one cycle, MUL_A=12, MUL_B=13, then RES=156, RES_ID=1, RES_VALID one cycle, REQ dropped on ACK -> no repeat.
- Fairness: all REQ held high from reset -> RES_ID sequence 0,1,2,3,0,1; every transaction takes 6 cycles.
- Operand extremes: 255x255 -> RES=0xFE01; 0x200 -> RES=0.
- Spurious DONE: MUL_DONE held at 1 with REQ=0 -> RES_VALID stays 0. Then REQ=0001 -> exactly one RES_VALID, and MUL_START is still issued.
- Reset mid-operation: RST pulsed while in WAIT -> BUSY=0 next cycle and no RES_VALID. With REQ=1001 afterwards -> requester 0 is served first (PTR=0).
- Timeout (macro defined, TIMEOUT=64): model never asserts DONE -> RES_VALID with ERR=1 and RES=0 after 64 WAIT cycles, then the next requester is served normally.
